// File: rtl/sram16_word_ctrl.sv
// Host-side word controller for the 16x1 dual-read SRAM macro: serialises word writes
// bit by bit through port 1 and gathers word reads through one or both read ports.
module sram16_word_ctrl #(
    parameter bit DUAL_READ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        busy,
    output logic [3:0]  sram_addr1,
    output logic [3:0]  sram_addr2,
    output logic        sram_wline,
    output logic        sram_rdwr,
    output logic        sram_deven,
    input  logic        sram_rline1,
    input  logic        sram_rline2
);

    typedef enum logic [2:0] {
        IDLE,
        WSETUP,
        WRITE,
        WDONE,
        RSETUP,
        READ,
        RLAST,
        RESP
    } state_t;

    // Address advance per read beat and the address pair held during the final beat.
    localparam logic [3:0] ADDR_STEP = DUAL_READ ? 4'd2 : 4'd1;
    localparam logic [3:0] LAST_READ = DUAL_READ ? 4'd14 : 4'd15;

    state_t      state;
    logic [15:0] wordBuf;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // NOTE: every SRAM pin is a flop updated with non-blocking assignments, so the macro
    // latches last cycle's address/data at the same edge this block advances on.
    // sram_rdwr only ever changes on an edge that also leaves sram_deven high, so the
    // macro never sees a write enable against a stale latched address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wordBuf    <= '0;
            sram_deven <= 1'b1;
            sram_rdwr  <= 1'b0;
            sram_addr1 <= '0;
            sram_addr2 <= '0;
            sram_wline <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        wordBuf    <= cmd_wdata;
                        sram_addr1 <= 4'd0;
                        if (cmd_wr) begin
                            state      <= WSETUP;
                            sram_rdwr  <= 1'b1;
                            sram_wline <= cmd_wdata[0];
                        end else begin
                            state      <= RSETUP;
                            sram_addr2 <= DUAL_READ ? 4'd1 : 4'd0;
                        end
                    end
                end

                WSETUP: begin
                    state      <= WRITE;
                    sram_deven <= 1'b0;
                    sram_addr1 <= 4'd1;
                    sram_wline <= wordBuf[1];
                end

                WRITE: begin
                    if (sram_addr1 == 4'd15) begin
                        state <= WDONE;
                    end else begin
                        sram_addr1 <= sram_addr1 + 4'd1;
                        sram_wline <= wordBuf[sram_addr1 + 4'd1];
                    end
                end

                WDONE: begin
                    state      <= IDLE;
                    sram_deven <= 1'b1;
                    sram_rdwr  <= 1'b0;
                end

                RSETUP: begin
                    state      <= READ;
                    sram_deven <= 1'b0;
                    sram_addr1 <= ADDR_STEP;
                    if (DUAL_READ) begin
                        sram_addr2 <= ADDR_STEP + 4'd1;
                    end
                end

                // Read data on the lines belongs to the address pair driven one beat earlier.
                READ: begin
                    rsp_rdata[sram_addr1 - ADDR_STEP] <= sram_rline1;
                    if (DUAL_READ) begin
                        rsp_rdata[sram_addr2 - ADDR_STEP] <= sram_rline2;
                    end
                    if (sram_addr1 == LAST_READ) begin
                        state <= RLAST;
                    end else begin
                        sram_addr1 <= sram_addr1 + ADDR_STEP;
                        if (DUAL_READ) begin
                            sram_addr2 <= sram_addr2 + ADDR_STEP;
                        end
                    end
                end

                RLAST: begin
                    rsp_rdata[sram_addr1] <= sram_rline1;
                    if (DUAL_READ) begin
                        rsp_rdata[sram_addr2] <= sram_rline2;
                    end
                    state      <= RESP;
                    sram_deven <= 1'b1;
                    rsp_valid  <= 1'b1;
                end

                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
